bus_arbiter: RTL and testbench



---
 rtl/bus_arbiter_pkg.sv | 20 ++
 rtl/bus_arbiter_rr_pick.sv | 42 ++++
 rtl/bus_arbiter.sv | 193 +++++++++++++++++++
 tb/tb_bus_arbiter.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the internal data-bus arbiter and the key-compare
// mux chain it drives.
//   arb_state_e        : arbiter state encodings (IDLE / OWN / TURN)
//   BUS_DEF_CODE_BASE  : default key code of requester 0
//   BUS_DEF_IDLE_CODE  : default key that matches no mux in the chain
// -----------------------------------------------------------------------------
package bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_OWN  = 2'd1,
        ARB_TURN = 2'd2
    } arb_state_e;

    localparam logic [7:0] BUS_DEF_CODE_BASE = 8'h10;
    localparam logic [7:0] BUS_DEF_IDLE_CODE = 8'h00;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin finder. Returns the first set request bit found
// searching ptr, ptr+1, ... with wrap-around.
// Ports:
//   req   in  NUM_REQ  request vector
//   ptr   in  PW       search start index
//   found out 1        any request set
//   index out PW       winning requester index (0 when found=0)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      ptr,
    output logic               found,
    output logic [PW-1:0]      index
);

    logic [NUM_REQ-1:0]   mask;
    logic [2*NUM_REQ-1:0] dbl;

    // Lower half keeps only bits at or above ptr; upper half is the full
    // vector, so the lowest set bit of the doubled word is the wrapped winner.
    always_comb begin
        mask = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            mask[i] = (PW'(i) >= ptr);
        end
        dbl   = {req, req & mask};
        found = 1'b0;
        index = '0;
        for (int i = 2*NUM_REQ-1; i >= 0; i--) begin
            if (dbl[i]) begin
                found = 1'b1;
                index = (i >= NUM_REQ) ? PW'(i - NUM_REQ) : PW'(i);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// -----------------------------------------------------------------------------
// bus_arbiter
// Round-robin owner selection for the internal data bus. Produces the select
// key for the key-compare mux chain: CODE_BASE+i while requester i owns the
// bus, IDLE_CODE otherwise. Tenure is bounded to MAX_HOLD cycles whenever
// another requester is waiting. All outputs are registered.
//
// Build option: BUS_ARB_TURNAROUND_EN
//   defined   : every release passes through one dead TURN cycle
//   undefined : release hands off directly to the next winner (no TURN)
//
// Ports:
//   clk    in  1         system clock, rising edge
//   rst_n  in  1         asynchronous active-low reset
//   req    in  NUM_REQ   per-requester level request
//   grant  out NUM_REQ   one-hot grant, zero when unowned
//   key    out KEY_SIZE  mux chain select code
//   busy   out 1         any grant asserted
//   owner  out PW        current / last owner index
//
// state | meaning
// IDLE  | no owner, key = IDLE_CODE
// OWN   | grant[owner]=1, key = CODE_BASE+owner
// TURN  | one dead cycle after a release (turnaround build only)
// -----------------------------------------------------------------------------
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int                  NUM_REQ   = 4,
    parameter int                  KEY_SIZE  = 8,
    parameter logic [KEY_SIZE-1:0] CODE_BASE = KEY_SIZE'(BUS_DEF_CODE_BASE),
    parameter logic [KEY_SIZE-1:0] IDLE_CODE = KEY_SIZE'(BUS_DEF_IDLE_CODE),
    parameter int                  MAX_HOLD  = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    output logic [NUM_REQ-1:0]         grant,
    output logic [KEY_SIZE-1:0]        key,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] owner
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int HW = $clog2(MAX_HOLD + 1);

    generate
        if (NUM_REQ < 2 || NUM_REQ > 16) begin : g_bad_num_req
            $error("bus_arbiter: NUM_REQ must be 2..16");
        end
        if (MAX_HOLD < 1) begin : g_bad_max_hold
            $error("bus_arbiter: MAX_HOLD must be >= 1");
        end
        if (longint'(CODE_BASE) + longint'(NUM_REQ) - 1 > (longint'(1) << KEY_SIZE) - 1) begin : g_code_ovf
            $error("bus_arbiter: CODE_BASE+NUM_REQ-1 overflows KEY_SIZE");
        end
        if (longint'(IDLE_CODE) >= longint'(CODE_BASE) &&
            longint'(IDLE_CODE) <= longint'(CODE_BASE) + longint'(NUM_REQ) - 1) begin : g_idle_clash
            $error("bus_arbiter: IDLE_CODE collides with a requester code");
        end
    endgenerate

    arb_state_e          state_q, state_d;
    logic [NUM_REQ-1:0]  grant_q, grant_d;
    logic [KEY_SIZE-1:0] key_q,   key_d;
    logic                busy_q,  busy_d;
    logic [PW-1:0]       owner_q, owner_d;
    logic [PW-1:0]       ptr_q,   ptr_d;
    logic [HW-1:0]       hold_q,  hold_d;

    logic [PW-1:0] owner_nxt;
    logic [PW-1:0] pick_ptr;
    logic [PW-1:0] pick_idx;
    logic          pick_found;
    logic          others_pending;
    logic          at_limit;

    assign owner_nxt      = (owner_q == PW'(NUM_REQ - 1)) ? '0 : owner_q + PW'(1);
    assign others_pending = |(req & ~grant_q);
    assign at_limit       = (hold_q == HW'(MAX_HOLD - 1));

    // While owning, a release searches from the slot after the owner, which is
    // exactly the pointer value being written on that same edge.
    assign pick_ptr = (state_q == ARB_OWN) ? owner_nxt : ptr_q;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PW      (PW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        key_d   = key_q;
        busy_d  = busy_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;

        case (state_q)
            ARB_IDLE: begin
                if (pick_found) begin
                    state_d           = ARB_OWN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    key_d             = CODE_BASE + KEY_SIZE'(pick_idx);
                    owner_d           = pick_idx;
                    busy_d            = 1'b1;
                    hold_d            = '0;
                end
            end

            ARB_OWN: begin
                if (!req[owner_q] || (at_limit && others_pending)) begin
                    ptr_d   = owner_nxt;
                    grant_d = '0;
                    key_d   = IDLE_CODE;
                    busy_d  = 1'b0;
                    hold_d  = '0;
`ifdef BUS_ARB_TURNAROUND_EN
                    state_d = ARB_TURN;
`else
                    if (pick_found) begin
                        grant_d[pick_idx] = 1'b1;
                        key_d             = CODE_BASE + KEY_SIZE'(pick_idx);
                        owner_d           = pick_idx;
                        busy_d            = 1'b1;
                    end else begin
                        state_d = ARB_IDLE;
                    end
`endif
                end else if (!at_limit) begin
                    hold_d = hold_q + HW'(1);
                end
            end

`ifdef BUS_ARB_TURNAROUND_EN
            ARB_TURN: begin
                if (pick_found) begin
                    state_d           = ARB_OWN;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    key_d             = CODE_BASE + KEY_SIZE'(pick_idx);
                    owner_d           = pick_idx;
                    busy_d            = 1'b1;
                    hold_d            = '0;
                end else begin
                    state_d = ARB_IDLE;
                end
            end
`endif

            default: begin
                state_d = ARB_IDLE;
                grant_d = '0;
                key_d   = IDLE_CODE;
                busy_d  = 1'b0;
                hold_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            key_q   <= IDLE_CODE;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            key_q   <= key_d;
            busy_q  <= busy_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
        end
    end

    assign grant = grant_q;
    assign key   = key_q;
    assign busy  = busy_q;
    assign owner = owner_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter (default parameters). Stimulus pushes the
// expected tenure sequence (grant, key, owner, length, direct handoff) into a
// scoreboard queue; a negedge monitor pops an entry whenever a new tenure
// appears on the outputs and checks its length when it ends.
// -----------------------------------------------------------------------------
module tb_bus_arbiter;

`ifdef BUS_ARB_TURNAROUND_EN
    localparam bit TA = 1'b1;
`else
    localparam bit TA = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] grant;
    logic [7:0] key;
    logic       busy;
    logic [1:0] owner;

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        logic [3:0] grant;
        logic [7:0] key;
        logic [1:0] owner;
        int         len;     // 0 = tenure length not checked
        bit         direct;  // tenure starts with no dead cycle before it
    } exp_t;

    exp_t sbq[$];

    always #5 clk = ~clk;

    bus_arbiter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .grant (grant),
        .key   (key),
        .busy  (busy),
        .owner (owner)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push(input logic [3:0] g, input logic [7:0] k, input logic [1:0] o,
                        input int len, input bit direct);
        exp_t e;
        e.grant = g; e.key = k; e.owner = o; e.len = len; e.direct = direct;
        sbq.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Starts and ends one time unit after a rising edge; reset is low across
    // one falling edge so the monitor sees it.
    task automatic reset_pulse();
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- monitor ----------------
    logic [3:0] prev_g = 4'b0000;
    bit         active = 1'b0;
    int         len_cnt = 0;
    exp_t       cur;

    always @(negedge clk) begin
        logic [7:0] mkey;
        if (!rst_n) begin
            prev_g  = 4'b0000;
            active  = 1'b0;
            len_cnt = 0;
        end else begin
            n_chk++;
            assert ($onehot0(grant)) else begin
                n_fail++;
                $display("FAIL onehot: grant=%b at %0t", grant, $time);
            end
            mkey = 8'h00;
            for (int i = 0; i < 4; i++) if (grant[i]) mkey = 8'h10 + 8'(i);
            chk("key_vs_grant", key, mkey);
            chk("busy_vs_grant", busy, grant != 4'b0000);

            if (grant != prev_g) begin
                if (prev_g != 4'b0000 && active) begin
                    if (cur.len != 0) chk("tenure_len", len_cnt, cur.len);
                    active = 1'b0;
                end
                if (grant != 4'b0000) begin
                    if (sbq.size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL sb_unexpected: grant=%b with empty queue at %0t", grant, $time);
                    end else begin
                        cur = sbq.pop_front();
                        chk("sb_grant", grant, cur.grant);
                        chk("sb_key", key, cur.key);
                        chk("sb_owner", owner, cur.owner);
                        chk("sb_direct", prev_g != 4'b0000, cur.direct);
                        active  = 1'b1;
                        len_cnt = 1;
                    end
                end
            end else if (grant != 4'b0000) begin
                len_cnt++;
            end
            prev_g = grant;
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset state
        #3;
        chk("rst_grant", grant, 4'b0000);
        chk("rst_key", key, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_owner", owner, 2'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // 1: reset mid-tenure, then 1-cycle grant latency
        req = 4'b0010;
        push(4'b0010, 8'h11, 2'd1, 0, 1'b0);
        tick();
        tick();
        tick();
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_grant", grant, 4'b0000);
        chk("midrst_key", key, 8'h00);
        chk("midrst_busy", busy, 1'b0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(4'b0010, 8'h11, 2'd1, 2, 1'b0);
        tick();
        chk("lat_grant", grant, 4'b0010);
        chk("lat_key", key, 8'h11);
        tick();
        req = 4'b0000;
        tick();

        // 6: idle after release
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_busy", busy, 1'b0);
            chk("idle_key", key, 8'h00);
            chk("idle_grant", grant, 4'b0000);
        end

        // 2: round robin 0,1,2,3,0
        reset_pulse();
        req = 4'b1111;
        push(4'b0001, 8'h10, 2'd0, 2, 1'b0);
        push(4'b0010, 8'h11, 2'd1, 2, !TA);
        push(4'b0100, 8'h12, 2'd2, 2, !TA);
        push(4'b1000, 8'h13, 2'd3, 2, !TA);
        push(4'b0001, 8'h10, 2'd0, 2, !TA);
        tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            if (k == 4) req = 4'b0000;
            else        req[k % 4] = 1'b0;
            tick();
            if (k < 4) req[k % 4] = 1'b1;
            if (TA) tick();
        end
        repeat (3) tick();

        // 3: starvation bound
        reset_pulse();
        req = 4'b0001;
        push(4'b0001, 8'h10, 2'd0, 16, 1'b0);
        push(4'b0100, 8'h12, 2'd2, TA ? 3 : 4, !TA);
        tick();
        repeat (4) tick();
        req = 4'b0101;
        repeat (12) tick();
        repeat (3) tick();
        req = 4'b0000;
        repeat (3) tick();

        // 4: sole requester keeps the bus
        req = 4'b1000;
        push(4'b1000, 8'h13, 2'd3, 101, 1'b0);
        tick();
        repeat (100) tick();
        req = 4'b0000;
        repeat (3) tick();

        // 5: simultaneous release and new requests
        reset_pulse();
        req = 4'b0010;
        push(4'b0010, 8'h11, 2'd1, 2, 1'b0);
        push(4'b1000, 8'h13, 2'd3, 2, !TA);
        push(4'b0001, 8'h10, 2'd0, 2, !TA);
        tick();
        tick();
        req = 4'b1001;
        tick();
        if (TA) tick();
        tick();
        req = 4'b0001;
        tick();
        if (TA) tick();
        tick();
        req = 4'b0000;
        repeat (5) tick();

        chk("sb_drained", sbq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
